// File: rtl/rv_iopmp_pkg.sv
// Types and IOPMP error-capture register offsets shared by the error-record reader.
package rv_iopmp_pkg;

    localparam logic [31:0] ERR_REQINFO_OFF  = 32'h60;
    localparam logic [31:0] ERR_REQID_OFF    = 32'h64;
    localparam logic [31:0] ERR_REQADDR_OFF  = 32'h68;
    localparam logic [31:0] ERR_REQADDRH_OFF = 32'h6C;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } iopmp_reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } iopmp_reg_rsp_t;

    typedef struct packed {
        logic [1:0]  ttype;
        logic [2:0]  etype;
        logic [15:0] sid;
        logic [15:0] eid;
        logic [63:0] addr;
    } err_record_t;

    typedef enum logic [2:0] {
        IDLE,
        RD_INFO,
        RD_ID,
        RD_ADDR,
        RD_ADDRH,
        CLR
    } rd_state_e;

    // CLR targets the info register again: writing 1 to v releases the capture.
    function automatic logic [31:0] state_reg_off(rd_state_e s);
        case (s)
            RD_ID:    return ERR_REQID_OFF;
            RD_ADDR:  return ERR_REQADDR_OFF;
            RD_ADDRH: return ERR_REQADDRH_OFF;
            default:  return ERR_REQINFO_OFF;
        endcase
    endfunction

endpackage

// File: rtl/rv_iopmp_err_reader_if.sv
// Register-interface bundle between the reader (master) and the IOPMP register map (slave).
interface rv_iopmp_err_reader_if
    import rv_iopmp_pkg::*;
#(
    parameter type reg_req_t = iopmp_reg_req_t,
    parameter type reg_rsp_t = iopmp_reg_rsp_t
) ();

    reg_req_t req;
    reg_rsp_t rsp;

    modport master (output req, input rsp);
    modport slave  (input req, output rsp);

endinterface

// File: rtl/fifo_v3.sv
// Synchronous FIFO with the common_cells fifo_v3 port shape; a push while full is accepted when a pop happens in the same cycle.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    parameter type         dtype        = logic [DATA_WIDTH-1:0]
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    output logic full_o,
    output logic empty_o,
    input  dtype data_i,
    input  logic push_i,
    output dtype data_o,
    input  logic pop_i
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    dtype          mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, wr_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          bypass, do_pop, rd_adv, wr_en;

    assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
    assign empty_o = (cnt_q == '0) && !bypass;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign rd_adv  = do_pop && !bypass;
    assign wr_en   = push_i && (!full_o || do_pop) && !(bypass && do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_adv) rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_adv);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rv_iopmp_err_reader_fsm.sv
// Access sequencer: reads the IOPMP error capture registers one at a time, assembles the record, then clears v.
module rv_iopmp_err_reader_fsm
    import rv_iopmp_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         wsi_i,
    input  logic                         poll_i,
    rv_iopmp_err_reader_if.master        bus,
    output logic                         push_o,
    output err_record_t                  rec_o,
    output logic                         bus_err_o,
    output logic                         busy_o
);

    rd_state_e   state_q, state_d;
    err_record_t rec_q, rec_d;
    logic        bus_err_q, bus_err_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        rec_q <= rec_d;
    end

    // Request fields depend only on state, so they stay put while ready is low.
    always_comb begin
        state_d   = state_q;
        rec_d     = rec_q;
        bus_err_d = bus_err_q;
        push_o    = 1'b0;
        bus.req   = '0;

        if (state_q == IDLE) begin
            if (wsi_i || poll_i) state_d = RD_INFO;
        end else begin
            bus.req.valid = 1'b1;
            bus.req.wstrb = 4'hF;
            bus.req.addr  = BASE_ADDR + state_reg_off(state_q);
            bus.req.write = (state_q == CLR);
            bus.req.wdata = (state_q == CLR) ? 32'h1 : 32'h0;

            if (bus.rsp.ready) begin
                if (bus.rsp.error) begin
                    bus_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    case (state_q)
                        RD_INFO: begin
                            if (bus.rsp.rdata[0]) begin
                                rec_d.ttype = bus.rsp.rdata[2:1];
                                rec_d.etype = bus.rsp.rdata[6:4];
                                state_d     = RD_ID;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                        RD_ID: begin
                            rec_d.sid = bus.rsp.rdata[15:0];
                            rec_d.eid = bus.rsp.rdata[31:16];
                            state_d   = RD_ADDR;
                        end
                        RD_ADDR: begin
                            rec_d.addr[31:0] = bus.rsp.rdata;
                            state_d          = RD_ADDRH;
                        end
                        RD_ADDRH: begin
                            rec_d.addr[63:32] = bus.rsp.rdata;
                            state_d           = CLR;
                        end
                        CLR: begin
                            push_o  = 1'b1;
                            state_d = IDLE;
                        end
                        default: state_d = IDLE;
                    endcase
                end
            end
        end
    end

    assign rec_o     = rec_q;
    assign bus_err_o = bus_err_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: rtl/rv_iopmp_err_reader.sv
// IOPMP error-record reader: drains the error capture registers on interrupt or poll into a record queue.
module rv_iopmp_err_reader
    import rv_iopmp_pkg::*;
#(
    parameter type         reg_req_t  = iopmp_reg_req_t,
    parameter type         reg_rsp_t  = iopmp_reg_rsp_t,
    parameter logic [31:0] BASE_ADDR  = 32'h0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wsi_i,
    input  logic        poll_i,
    output reg_req_t    cfg_req_o,
    input  reg_rsp_t    cfg_rsp_i,
    output logic        rec_valid_o,
    output err_record_t rec_o,
    input  logic        rec_ready_i,
    output logic [7:0]  drop_cnt_o,
    output logic        bus_err_o,
    output logic        busy_o
);

    rv_iopmp_err_reader_if #(
        .reg_req_t (reg_req_t),
        .reg_rsp_t (reg_rsp_t)
    ) bus ();

    assign cfg_req_o = bus.req;
    assign bus.rsp   = cfg_rsp_i;

    logic        rec_push;
    err_record_t rec_cur;

    rv_iopmp_err_reader_fsm #(
        .BASE_ADDR (BASE_ADDR)
    ) u_fsm (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wsi_i     (wsi_i),
        .poll_i    (poll_i),
        .bus       (bus),
        .push_o    (rec_push),
        .rec_o     (rec_cur),
        .bus_err_o (bus_err_o),
        .busy_o    (busy_o)
    );

    logic fifo_full, fifo_empty, fifo_push, fifo_pop, drop;

    // A pop in the same cycle frees the slot, so a full queue still takes the push.
    assign fifo_pop  = rec_ready_i && !fifo_empty;
    assign fifo_push = rec_push && (!fifo_full || fifo_pop);
    assign drop      = rec_push && fifo_full && !fifo_pop;

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DEPTH        (FIFO_DEPTH),
        .dtype        (err_record_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .flush_i (1'b0),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .data_i  (rec_cur),
        .push_i  (fifo_push),
        .data_o  (rec_o),
        .pop_i   (fifo_pop)
    );

    assign rec_valid_o = !fifo_empty;

    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_rv_iopmp_err_reader.sv
// Directed bench for rv_iopmp_err_reader with a behavioural IOPMP register-map responder.
module tb_rv_iopmp_err_reader;
    import rv_iopmp_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wsi = 1'b0;
    logic        poll = 1'b0;
    logic        rec_ready = 1'b0;
    logic        rec_valid;
    err_record_t rec;
    logic [7:0]  drop_cnt;
    logic        bus_err;
    logic        busy;

    rv_iopmp_err_reader_if reg_bus ();

    rv_iopmp_err_reader #(
        .BASE_ADDR  (32'h0),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .wsi_i       (wsi),
        .poll_i      (poll),
        .cfg_req_o   (reg_bus.req),
        .cfg_rsp_i   (reg_bus.rsp),
        .rec_valid_o (rec_valid),
        .rec_o       (rec),
        .rec_ready_i (rec_ready),
        .drop_cnt_o  (drop_cnt),
        .bus_err_o   (bus_err),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    // Register-map model configuration (driven by the stimulus process)
    logic [31:0] info_val  = 32'h0;
    logic [31:0] id_val    = 32'h0;
    logic [31:0] addr_val  = 32'h0;
    logic [31:0] addrh_val = 32'h0;
    logic [31:0] err_addr  = 32'hFFFF_FFFF;
    int          rdy_lat   = 0;
    logic        arm       = 1'b0;

    // Register-map model state
    logic           v_q        = 1'b0;
    int             wait_cnt   = 0;
    logic           pend       = 1'b0;
    iopmp_reg_req_t prev_req   = '0;
    int             n_info_rd  = 0;
    int             n_clr_wr   = 0;
    int             n_bad      = 0;
    int             n_acc      = 0;
    int             n_unstable = 0;

    always_comb begin
        reg_bus.rsp = '0;
        if (reg_bus.req.valid && (wait_cnt >= rdy_lat)) begin
            reg_bus.rsp.ready = 1'b1;
            reg_bus.rsp.error = (reg_bus.req.addr == err_addr);
            case (reg_bus.req.addr)
                32'h60:  reg_bus.rsp.rdata = {info_val[31:1], v_q};
                32'h64:  reg_bus.rsp.rdata = id_val;
                32'h68:  reg_bus.rsp.rdata = addr_val;
                32'h6C:  reg_bus.rsp.rdata = addrh_val;
                default: reg_bus.rsp.rdata = 32'h0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (reg_bus.req.valid && !reg_bus.rsp.ready) wait_cnt <= wait_cnt + 1;
        else                                         wait_cnt <= 0;
        pend     <= reg_bus.req.valid && !reg_bus.rsp.ready && !rst;
        prev_req <= reg_bus.req;
        if (pend && !rst && (reg_bus.req !== prev_req)) n_unstable <= n_unstable + 1;
        if (arm) v_q <= 1'b1;
        if (reg_bus.req.valid && reg_bus.rsp.ready && !reg_bus.rsp.error && !rst) begin
            n_acc <= n_acc + 1;
            if (reg_bus.req.wstrb != 4'hF) n_bad <= n_bad + 1;
            if (reg_bus.req.write) begin
                if (reg_bus.req.addr == 32'h60 && reg_bus.req.wdata == 32'h1) begin
                    n_clr_wr <= n_clr_wr + 1;
                    v_q      <= 1'b0;
                end else begin
                    n_bad <= n_bad + 1;
                end
            end else if (reg_bus.req.addr == 32'h60) begin
                n_info_rd <= n_info_rd + 1;
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic irq_pulse();
        @(negedge clk);
        arm = 1'b1;
        wsi = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        wsi = 1'b0;
    endtask

    task automatic irq_seq();
        irq_pulse();
        repeat (6) @(negedge clk);
    endtask

    task automatic pop_chk(input string tag, input logic [15:0] sid);
        @(negedge clk);
        chk({tag, "_vld"}, rec_valid, 1'b1);
        chk({tag, "_sid"}, rec.sid, sid);
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
    endtask

    task automatic wait_rec(input string tag, input int budget);
        int n = 0;
        while (!rec_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(tag, rec_valid, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: no summary within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        err_record_t exp_rec;
        int c_clr, c_info, c_acc, c_uns;
        int k;

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rec_valid", rec_valid, 1'b0);
        chk("rst_drop", drop_cnt, 8'h00);
        chk("rst_bus_err", bus_err, 1'b0);
        chk("rst_cfg_req", reg_bus.req, '0);
        rst = 1'b0;

        // Basic interrupt-driven record and its 6-cycle latency
        info_val = 32'h23; id_val = 32'h0005_0003; addr_val = 32'h8000_1000; addrh_val = 32'h0;
        c_clr = n_clr_wr;
        irq_pulse();
        repeat (4) @(negedge clk);
        chk("lat_cycle5", rec_valid, 1'b0);
        @(negedge clk);
        chk("lat_cycle6", rec_valid, 1'b1);
        exp_rec = '{ttype: 2'd1, etype: 3'd2, sid: 16'd3, eid: 16'd5, addr: 64'h8000_1000};
        chk("irq_record", rec, exp_rec);
        chk("irq_clear_writes", n_clr_wr - c_clr, 1);
        chk("irq_busy_done", busy, 1'b0);
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
        chk("irq_popped", rec_valid, 1'b0);

        // Poll with nothing captured
        info_val = 32'h0;
        c_info = n_info_rd; c_acc = n_acc;
        @(negedge clk); poll = 1'b1;
        @(negedge clk); poll = 1'b0;
        chk("poll_busy", busy, 1'b1);
        @(negedge clk);
        chk("poll_idle", busy, 1'b0);
        chk("poll_info_reads", n_info_rd - c_info, 1);
        chk("poll_accesses", n_acc - c_acc, 1);
        chk("poll_no_push", rec_valid, 1'b0);

        // Level wsi held across the clear: one re-read, poll while busy ignored
        info_val = 32'h23; id_val = 32'h0007_0009;
        c_info = n_info_rd; c_clr = n_clr_wr; c_acc = n_acc;
        @(negedge clk); wsi = 1'b1; arm = 1'b1;
        @(negedge clk); arm = 1'b0;
        @(negedge clk); poll = 1'b1;
        @(negedge clk); poll = 1'b0;
        repeat (4) @(negedge clk);
        wsi = 1'b0;
        repeat (4) @(negedge clk);
        chk("reread_info_reads", n_info_rd - c_info, 2);
        chk("reread_clears", n_clr_wr - c_clr, 1);
        chk("reread_accesses", n_acc - c_acc, 6);
        pop_chk("reread_pop", 16'h9);

        // Overflow: six records into a depth-4 queue
        c_clr = n_clr_wr;
        for (int i = 0; i < 6; i++) begin
            id_val = 32'(i);
            irq_seq();
        end
        chk("ovf_drop_cnt", drop_cnt, 8'd2);
        chk("ovf_clears", n_clr_wr - c_clr, 6);
        for (int i = 0; i < 4; i++) pop_chk("ovf_pop", 16'(i));
        @(negedge clk);
        chk("ovf_drained", rec_valid, 1'b0);

        // Push and pop together on a full queue
        for (int i = 0; i < 4; i++) begin
            id_val = 32'(10 + i);
            irq_seq();
        end
        id_val = 32'd14;
        irq_pulse();
        repeat (4) @(negedge clk);
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("fullpp_drop_cnt", drop_cnt, 8'd2);
        pop_chk("fullpp_pop", 16'd11);
        pop_chk("fullpp_pop", 16'd12);
        pop_chk("fullpp_pop", 16'd13);
        pop_chk("fullpp_pop", 16'd14);
        @(negedge clk);
        chk("fullpp_drained", rec_valid, 1'b0);

        // Slow register map: ready after 3 wait cycles
        rdy_lat = 3;
        info_val = 32'h75; id_val = 32'hBEEF_1234; addr_val = 32'hDEAD_0004; addrh_val = 32'h0000_00FF;
        c_uns = n_unstable; c_clr = n_clr_wr;
        irq_pulse();
        wait_rec("slow_wait", 60);
        exp_rec = '{ttype: 2'd2, etype: 3'd7, sid: 16'h1234, eid: 16'hBEEF, addr: 64'h0000_00FF_DEAD_0004};
        chk("slow_record", rec, exp_rec);
        chk("slow_req_stable", n_unstable - c_uns, 0);
        chk("slow_clears", n_clr_wr - c_clr, 1);
        chk("slow_bad_accesses", n_bad, 0);
        rec_ready = 1'b1;
        @(negedge clk);
        rec_ready = 1'b0;
        rdy_lat = 0;

        // Error response on the address read
        err_addr = 32'h68; info_val = 32'h23;
        c_clr = n_clr_wr; c_acc = n_acc;
        irq_seq();
        repeat (2) @(negedge clk);
        chk("err_bus_err", bus_err, 1'b1);
        chk("err_no_clear", n_clr_wr - c_clr, 0);
        chk("err_no_push", rec_valid, 1'b0);
        chk("err_idle", busy, 1'b0);
        chk("err_accesses", n_acc - c_acc, 2);
        err_addr = 32'hFFFF_FFFF;

        // Drop counter saturation; bus_err stays sticky
        for (int i = 0; i < 264; i++) irq_seq();
        chk("sat_drop_cnt", drop_cnt, 8'hFF);
        chk("sat_bus_err_sticky", bus_err, 1'b1);
        chk("sat_queue_full", rec_valid, 1'b1);

        // Reset in the middle of the ID read
        rdy_lat = 3;
        irq_pulse();
        k = 0;
        while (!(reg_bus.req.valid && reg_bus.req.addr == 32'h64) && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("rst_mid_in_rd_id", reg_bus.req.addr, 32'h64);
        rst = 1'b1;
        #1;
        chk("rst_mid_valid_now", reg_bus.req.valid, 1'b0);
        @(negedge clk);
        chk("rst_mid_valid", reg_bus.req.valid, 1'b0);
        chk("rst_mid_rec_valid", rec_valid, 1'b0);
        chk("rst_mid_drop", drop_cnt, 8'h00);
        chk("rst_mid_bus_err", bus_err, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        rst = 1'b0;
        rdy_lat = 0;
        repeat (2) @(negedge clk);
        chk("rst_mid_stay_idle", busy, 1'b0);
        chk("rst_mid_req_zero", reg_bus.req, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_iopmp_err_reader.md
RV_IOPMP_ERR_READER -- requirements
Module: rv_iopmp_err_reader

Interface
REQ-001 SHALL have parameter reg_req_t, default logic: register-interface request type (addr, write, wdata[31:0], wstrb[3:0], valid).
REQ-002 SHALL have parameter reg_rsp_t, default logic: register-interface response type (rdata[31:0], error, ready).
REQ-003 SHALL have parameter BASE_ADDR, default 0: IOPMP register-space base added to every package offset.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: error-record queue depth, power of two, at least 2.
REQ-005 SHALL use one clock and an asynchronous active-high reset.
REQ-006 clk_i  in  1  rising-edge clock.
REQ-007 rst_i  in  1  asynchronous reset, active-high.
REQ-008 wsi_i  in  1  IOPMP wired-signalled interrupt, level, same clock domain.
REQ-009 poll_i  in  1  single-cycle software request to check the error record without an interrupt.
REQ-010 cfg_req_o  out  reg_req_t  register master request to the IOPMP register map.
REQ-011 cfg_rsp_i  in  reg_rsp_t  register map response.
REQ-012 rec_valid_o  out  1  record available at the queue head.
REQ-013 rec_o  out  err_record_t  queue head record.
REQ-014 rec_ready_i  in  1  consumer pops the head when rec_valid_o && rec_ready_i.
REQ-015 drop_cnt_o  out  8  count of records lost to a full queue, saturating.
REQ-016 bus_err_o  out  1  sticky flag: a register access returned error.
REQ-017 busy_o  out  1  FSM not in IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, RD_INFO, RD_ID, RD_ADDR, RD_ADDRH, CLR.
REQ-019 IDLE SHALL move to RD_INFO on (wsi_i | poll_i); otherwise it holds.
REQ-020 Each non-IDLE state SHALL drive exactly one access (valid=1, wstrb=4'hF), hold it stable until cfg_rsp_i.ready, and have one access outstanding at most.
REQ-021 RD_INFO SHALL read BASE_ADDR+ERR_REQINFO_OFF; if rdata[0] (v) is 0, SHALL return to IDLE with no record; otherwise it captures ttype=rdata[2:1] and etype=rdata[6:4] and moves to RD_ID.
REQ-022 RD_ID SHALL read ERR_REQID_OFF and capture sid=rdata[15:0], eid=rdata[31:16].
REQ-023 RD_ADDR SHALL read ERR_REQADDR_OFF and capture addr[31:0].
REQ-024 RD_ADDRH SHALL read ERR_REQADDRH_OFF and capture addr[63:32].
REQ-025 CLR SHALL write 32'h1 to ERR_REQINFO_OFF (W1C of v); on its handshake it pushes the record and returns to IDLE.
REQ-026 With ready tied high, a record SHALL be visible at rec_valid_o 6 cycles after IDLE samples the trigger (cycle 0).
REQ-027 A push with the queue full SHALL drop the record and increment drop_cnt_o, saturating at 8'hFF; the clear write is still performed.
REQ-028 A simultaneous push and pop on a full queue SHALL succeed with no drop.
REQ-029 A response with error=1 SHALL set bus_err_o, abandon the sequence with no push and no clear, and return to IDLE; bus_err_o clears only on reset.
REQ-030 If wsi_i is still high on return to IDLE (clear latency), the reader SHALL re-read; a read of v=0 ends the sequence cleanly.
REQ-031 Triggers arriving while busy_o=1 SHALL be ignored (poll_i not queued).
REQ-032 cfg_req_o.valid SHALL be low in IDLE.

Reset
REQ-033 On rst_i the reader SHALL enter IDLE, empty the queue, and reset drop_cnt_o=0, bus_err_o=0, busy_o=0, rec_valid_o=0, cfg_req_o='0; reset mid-access abandons the access immediately.

Structure
REQ-034 rv_iopmp_pkg SHALL hold err_record_t {ttype[1:0], etype[2:0], sid[15:0], eid[15:0], addr[63:0]} and ERR_REQINFO_OFF=0x60, ERR_REQID_OFF=0x64, ERR_REQADDR_OFF=0x68, ERR_REQADDRH_OFF=0x6C.
REQ-035 The queue SHALL be one fifo_v3 instance (common_cells, FALL_THROUGH=0, DEPTH=FIFO_DEPTH), with flush tied low and rst_ni driven by ~rst_i.

Verification
REQ-036 wsi_i=1, INFO=0x23, ID=0x0005_0003, ADDR=0x8000_1000, ADDRH=0 -> record {ttype=1, etype=2, sid=3, eid=5, addr=0x8000_1000}, then a write of 0x1 to 0x60.
REQ-037 poll_i pulse with INFO=0x0 -> one read of 0x60, busy_o for 1 access, no push.
REQ-038 rec_ready_i=0 and 6 interrupts with FIFO_DEPTH=4 -> 4 records held, drop_cnt_o=2, and 6 clear writes seen.
REQ-039 error=1 on the RD_ADDR response -> bus_err_o=1, no clear write, queue unchanged, IDLE.
REQ-040 ready delayed 3 cycles per access -> request fields stable throughout, record correct.
REQ-041 rst_i asserted during RD_ID -> cfg_req_o.valid=0 next cycle, queue empty, counters 0.
